// File: rtl/wr_port_arbiter_9way.sv
//------------------------------------------------------------------------------
// Module  : wr_port_arbiter_9way
// Brief   : Two-class round-robin arbiter for one VGPR write port (9 requesters).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wr_port_arbiter_9way #(
  parameter logic [8:0] HIPRI_MASK   = 9'h000,
  parameter logic [3:0] STARVE_LIMIT = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  port_req,
  input  logic        wr_hold,
  output logic [8:0]  port_grant,
  output logic [15:0] wr_port_select,
  output logic        arb_starve
);

  logic [8:0] grant_q, grant_d;
  logic       starve_q, starve_d;
  logic [3:0] hi_ptr_q, hi_ptr_d;
  logic [3:0] lo_ptr_q, lo_ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic [8:0] elig, hi, lo;
  logic [3:0] hi_win, lo_win;
  logic       lo_wait, take_lo;

  // First set bit of vec at or above ptr, wrapping 8 -> 0.
  function automatic logic [3:0] rr_pick(input logic [8:0] vec, input logic [3:0] ptr);
    logic [4:0] idx;
    logic [3:0] sel;
    logic       hit;
    sel = 4'd0;
    hit = 1'b0;
    for (int k = 0; k < 9; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'd9) idx = idx - 5'd9;
      if (!hit && vec[idx[3:0]]) begin
        hit = 1'b1;
        sel = idx[3:0];
      end
    end
    return sel;
  endfunction

  function automatic logic [3:0] ptr_after(input logic [3:0] win);
    return (win == 4'd8) ? 4'd0 : win + 4'd1;
  endfunction

  always_comb begin
    elig    = port_req & ~grant_q;
    hi      = elig & HIPRI_MASK;
    lo      = elig & ~HIPRI_MASK;
    // A low port still requesting right after its grant is waiting on its next write.
    lo_wait = |(port_req & ~HIPRI_MASK);
    hi_win  = rr_pick(hi, hi_ptr_q);
    lo_win  = rr_pick(lo, lo_ptr_q);
    take_lo = (lo != 9'd0) &&
              ((hi == 9'd0) || ((STARVE_LIMIT != 4'd0) && (cnt_q == STARVE_LIMIT)));

    grant_d  = 9'd0;
    starve_d = 1'b0;
    hi_ptr_d = hi_ptr_q;
    lo_ptr_d = lo_ptr_q;
    cnt_d    = cnt_q;

    if (!wr_hold) begin
      if (take_lo) begin
        grant_d  = 9'd1 << lo_win;
        starve_d = (hi != 9'd0);
        lo_ptr_d = ptr_after(lo_win);
        cnt_d    = 4'd0;
      end else if (hi != 9'd0) begin
        grant_d  = 9'd1 << hi_win;
        hi_ptr_d = ptr_after(hi_win);
        if (!lo_wait)                 cnt_d = 4'd0;
        else if (cnt_q < STARVE_LIMIT) cnt_d = cnt_q + 4'd1;
        else                          cnt_d = STARVE_LIMIT;
      end else begin
        cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= 9'd0;
      starve_q <= 1'b0;
      hi_ptr_q <= 4'd0;
      lo_ptr_q <= 4'd0;
      cnt_q    <= 4'd0;
    end else begin
      grant_q  <= grant_d;
      starve_q <= starve_d;
      hi_ptr_q <= hi_ptr_d;
      lo_ptr_q <= lo_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign port_grant     = grant_q;
  assign wr_port_select = {7'd0, grant_q};
  assign arb_starve     = starve_q;

endmodule

`default_nettype wire
